mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore-style multicycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles. It drives the datapath select/enable lines using the same Aluop encoding and branch-select (pcs) convention as the single-cycle decoder. Memory accesses use a ready handshake with a wait-timeout guard.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready in any memory state before abort (1..255)
CNT_W, 8, width of internal wait counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction [31:26] from IR, sampled in DECODE
func  in  6  instruction [5:0] from IR, sampled in DECODE
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory completes current access this cycle
pc_wr  out  1  PC load enable
ir_wr  out  1  IR load enable
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
reg_dst  out  1  dest select: 1=rd, 0=rt
reg_wr  out  1  register file write enable
mem2reg  out  1  writeback select: 1=MDR, 0=ALUOut
alu_srca  out  1  0=PC, 1=regA
alu_srcb  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
Aluop  out  3  ALU operation code
pcs  out  1  PC source: 1=branch target (ALUOut), 0=ALU result
illegal  out  1  one-cycle pulse on unsupported opcode/func
mem_err  out  1  one-cycle pulse on memory timeout
state  out  4  current state code (debug)

Behaviour:
- Reset (async, active-high): state=FETCH(0), wait counter=0, held opcode/func=0, all outputs 0. Outputs are forced 0 while reset is high.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8. Codes 9-15 go to FETCH next cycle with all outputs 0.
- Outputs are a function of state only, plus the held func, zero and mem_ready as noted below. Any output not listed for a state is 0.
- FETCH: mem_rd=1, alu_srcb=01, Aluop=010. ir_wr and pc_wr = mem_ready. On mem_ready go to DECODE, otherwise stay.
- DECODE: alu_srcb=11, Aluop=010. Latch opcode/func. Next state:
  - 100011 or 101011 -> MEMADR
  - 000000 with func in {100000, 100001, 100010, 100011, 100100} -> EXEC
  - 000100 -> BRANCH
  - anything else -> illegal=1 this cycle, then FETCH
- MEMADR: alu_srca=1, alu_srcb=10, Aluop=010. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_rd=1. On mem_ready go to MEMWB, otherwise wait.
- MEMWB: reg_wr=1, reg_dst=0, mem2reg=1. Next FETCH.
- MEMWR: iord=1, mem_wr=1, held until mem_ready. On mem_ready go to FETCH.
- EXEC: alu_srca=1, alu_srcb=00. Aluop by held func: 100000->010, 100001->110, 100010->000, 100011->001, 100100->111. Next ALUWB.
- ALUWB: reg_wr=1, reg_dst=1, mem2reg=0. Next FETCH.
- BRANCH: alu_srca=1, alu_srcb=00, Aluop=110, pcs=1, pc_wr=zero. Next FETCH.
- Latency with zero-wait memory: beq 3, R-type 4, sw 4, lw 5 cycles. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- Wait counter:
  - Clears on entry to each memory state and when mem_ready=1.
  - Increments each cycle the FSM stays in FETCH/MEMRD/MEMWR with mem_ready=0.
  - When counter == MEM_TIMEOUT and mem_ready=0: mem_err=1 for that cycle, all write/load enables forced 0 that cycle, next state FETCH, counter cleared.
  - mem_ready=1 in the timeout cycle takes priority: normal completion, no mem_err.
- opcode/func changes outside DECODE have no effect.
- Reset mid-instruction: immediate return to FETCH, no partial writeback completes.

Test Plan:
- Reset high mid-MEMRD -> state=0, all outputs 0 asynchronously. After release with mem_ready=1: FETCH, pc_wr=ir_wr=1.
- R-type add (opcode 000000, func 100000), mem_ready=1 -> states 0,1,6,7. Aluop=010 in EXEC; reg_wr=reg_dst=1 in ALUWB; 4 cycles.
- lw (100011), then sw (101011), mem_ready=1 -> lw: 0,1,2,3,4 with mem2reg=1, reg_wr=1 in MEMWB. sw: 0,1,2,5 with mem_wr=1, iord=1.
- beq (000100) with zero=1, then with zero=0 -> BRANCH shows Aluop=110 and pcs=1. pc_wr=1 and 0 respectively; 3 cycles each.
- opcode 000010, then R-type func 101010 -> illegal=1 pulse in DECODE, next state FETCH, no reg_wr/mem_wr anywhere.
- MEMWR with mem_ready held 0, MEM_TIMEOUT=15 -> mem_wr high for 15 cycles, mem_err pulse on the 16th, then FETCH. A repeat with mem_ready=1 on the 16th cycle -> no mem_err, normal completion.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Moore-style multicycle sequencer for the MIPS datapath.
//                Steps each instruction through fetch / decode / execute /
//                memory / writeback. Memory states wait on mem_ready and are
//                guarded by a wait-timeout that aborts back to FETCH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_wr,
   output logic       ir_wr,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       reg_dst,
   output logic       reg_wr,
   output logic       mem2reg,
   output logic       alu_srca,
   output logic [1:0] alu_srcb,
   output logic [2:0] Aluop,
   output logic       pcs,
   output logic       illegal,
   output logic       mem_err,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      c_fetch  = 4'd0,
      c_decode = 4'd1,
      c_memadr = 4'd2,
      c_memrd  = 4'd3,
      c_memwb  = 4'd4,
      c_memwr  = 4'd5,
      c_exec   = 4'd6,
      c_aluwb  = 4'd7,
      c_branch = 4'd8
   } state_t;

   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);
   localparam logic [5:0]       c_op_rtype = 6'b000000;
   localparam logic [5:0]       c_op_lw    = 6'b100011;
   localparam logic [5:0]       c_op_sw    = 6'b101011;
   localparam logic [5:0]       c_op_beq   = 6'b000100;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [5:0]       r_opcode;
   logic [5:0]       r_func;
   logic             w_mem_state;
   logic             w_timeout;
   logic             w_func_ok;

   // States that talk to memory and therefore wait on mem_ready
   assign w_mem_state = (r_state == c_fetch) || (r_state == c_memrd) ||
                        (r_state == c_memwr);
   // Abort only when the limit is reached and memory is still not ready
   assign w_timeout   = w_mem_state && !mem_ready && (r_cnt == c_timeout);
   assign state       = r_state;

   // Supported R-type function codes, checked against the live IR in DECODE
   always_comb begin
      w_func_ok = 1'b0;
      case (func)
         6'b100000, 6'b100001, 6'b100010,
         6'b100011, 6'b100100: w_func_ok = 1'b1;
         default:              w_func_ok = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_fetch;
      else       r_state <= w_next;
   end

   // Wait counter: counts stalled memory cycles, zero everywhere else
   always_comb begin
      w_cnt_next = '0;
      if (w_mem_state && !mem_ready && !w_timeout)
         w_cnt_next = r_cnt + CNT_W'(1);
   end

   // Wait counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= '0;
      else       r_cnt <= w_cnt_next;
   end

   // Hold opcode/func from DECODE so later IR changes are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_opcode <= '0;
         r_func   <= '0;
      end else if (r_state == c_decode) begin
         r_opcode <= opcode;
         r_func   <= func;
      end
   end

   // Next-state and Moore outputs, timeout override, reset gating last
   always_comb begin
      w_next   = r_state;
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      iord     = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      reg_dst  = 1'b0;
      reg_wr   = 1'b0;
      mem2reg  = 1'b0;
      alu_srca = 1'b0;
      alu_srcb = 2'b00;
      Aluop    = 3'b000;
      pcs      = 1'b0;
      illegal  = 1'b0;
      mem_err  = 1'b0;

      case (r_state)
         c_fetch: begin
            mem_rd   = 1'b1;
            alu_srcb = 2'b01;
            Aluop    = 3'b010;
            ir_wr    = mem_ready;
            pc_wr    = mem_ready;
            if (mem_ready) w_next = c_decode;
         end
         c_decode: begin
            alu_srcb = 2'b11;
            Aluop    = 3'b010;
            if (opcode == c_op_lw || opcode == c_op_sw) begin
               w_next = c_memadr;
            end else if (opcode == c_op_rtype && w_func_ok) begin
               w_next = c_exec;
            end else if (opcode == c_op_beq) begin
               w_next = c_branch;
            end else begin
               illegal = 1'b1;
               w_next  = c_fetch;
            end
         end
         c_memadr: begin
            alu_srca = 1'b1;
            alu_srcb = 2'b10;
            Aluop    = 3'b010;
            w_next   = (r_opcode == c_op_lw) ? c_memrd : c_memwr;
         end
         c_memrd: begin
            iord   = 1'b1;
            mem_rd = 1'b1;
            if (mem_ready) w_next = c_memwb;
         end
         c_memwb: begin
            reg_wr  = 1'b1;
            mem2reg = 1'b1;
            w_next  = c_fetch;
         end
         c_memwr: begin
            iord   = 1'b1;
            mem_wr = 1'b1;
            if (mem_ready) w_next = c_fetch;
         end
         c_exec: begin
            alu_srca = 1'b1;
            case (r_func)
               6'b100000: Aluop = 3'b010;
               6'b100001: Aluop = 3'b110;
               6'b100010: Aluop = 3'b000;
               6'b100011: Aluop = 3'b001;
               6'b100100: Aluop = 3'b111;
               default:   Aluop = 3'b000;
            endcase
            w_next = c_aluwb;
         end
         c_aluwb: begin
            reg_wr  = 1'b1;
            reg_dst = 1'b1;
            w_next  = c_fetch;
         end
         c_branch: begin
            alu_srca = 1'b1;
            Aluop    = 3'b110;
            pcs      = 1'b1;
            pc_wr    = zero;
            w_next   = c_fetch;
         end
         default: w_next = c_fetch;
      endcase

      if (w_timeout) begin
         pc_wr   = 1'b0;
         ir_wr   = 1'b0;
         mem_wr  = 1'b0;
         reg_wr  = 1'b0;
         mem_err = 1'b1;
         w_next  = c_fetch;
      end

      if (reset) begin
         pc_wr    = 1'b0;
         ir_wr    = 1'b0;
         iord     = 1'b0;
         mem_rd   = 1'b0;
         mem_wr   = 1'b0;
         reg_dst  = 1'b0;
         reg_wr   = 1'b0;
         mem2reg  = 1'b0;
         alu_srca = 1'b0;
         alu_srcb = 2'b00;
         Aluop    = 3'b000;
         pcs      = 1'b0;
         illegal  = 1'b0;
         mem_err  = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Scoreboard bench for mips_multicycle_ctrl. Stimulus plays
//                whole instructions with chosen memory stall counts and
//                queues the expected per-cycle outputs; a monitor compares
//                them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

   localparam int T = 15;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_dst, reg_wr, mem2reg, alu_srca;
      logic [1:0] alu_srcb;
      logic [2:0] aluop;
      logic       pcs, illegal, mem_err;
   } exp_t;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] opcode, func;
   logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_dst, reg_wr, mem2reg;
   logic       alu_srca, pcs, illegal, mem_err;
   logic [1:0] alu_srcb;
   logic [2:0] Aluop;
   logic [3:0] state;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t m_exp, m_act;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .iord(iord),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_dst(reg_dst), .reg_wr(reg_wr),
      .mem2reg(mem2reg), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
      .Aluop(Aluop), .pcs(pcs), .illegal(illegal), .mem_err(mem_err),
      .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         m_exp = q.pop_front();
         m_act = {state, pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_dst, reg_wr,
                  mem2reg, alu_srca, alu_srcb, Aluop, pcs, illegal, mem_err};
         checks++;
         if (m_act !== m_exp) begin
            errors++;
            $display("FAIL cycle%0d outputs: got st=%0d bits=%b, expected st=%0d bits=%b (pc_wr ir_wr iord mem_rd mem_wr reg_dst reg_wr mem2reg srca srcb[2] aluop[3] pcs illegal mem_err)",
                     cyc, m_act.st, m_act[16:0], m_exp.st, m_exp[16:0]);
         end
         cyc++;
      end
   end

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   // Instruction classes: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq
   function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b100011) return 1;
      if (op == 6'b101011) return 2;
      if (op == 6'b000100) return 4;
      if (op == 6'b000000 && fn >= 6'b100000 && fn <= 6'b100100) return 3;
      return 0;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100001: return 3'b110;
         6'b100010: return 3'b000;
         6'b100011: return 3'b001;
         default:   return 3'b111;
      endcase
   endfunction

   // Expected visible outputs of each phase
   function automatic exp_t e_fetch(input logic rdy);
      exp_t e = '0;
      e.st = 4'd0; e.mem_rd = 1; e.alu_srcb = 2'b01; e.aluop = 3'b010;
      e.pc_wr = rdy; e.ir_wr = rdy;
      return e;
   endfunction

   function automatic exp_t e_decode(input logic ill);
      exp_t e = '0;
      e.st = 4'd1; e.alu_srcb = 2'b11; e.aluop = 3'b010; e.illegal = ill;
      return e;
   endfunction

   function automatic exp_t e_memadr();
      exp_t e = '0;
      e.st = 4'd2; e.alu_srca = 1; e.alu_srcb = 2'b10; e.aluop = 3'b010;
      return e;
   endfunction

   function automatic exp_t e_memrd();
      exp_t e = '0;
      e.st = 4'd3; e.iord = 1; e.mem_rd = 1;
      return e;
   endfunction

   function automatic exp_t e_memwr();
      exp_t e = '0;
      e.st = 4'd5; e.iord = 1; e.mem_wr = 1;
      return e;
   endfunction

   // Drive one cycle of inputs, queue its expectation, advance to next cycle
   task automatic step(input exp_t e, input logic rst_v, input logic mr,
                       input logic z, input logic [5:0] op, input logic [5:0] fn);
      reset = rst_v; mem_ready = mr; zero = z; opcode = op; func = fn;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   // Memory phase with k not-ready cycles before ready; aborts past T stalls
   task automatic mem_phase(input exp_t stall, input exp_t done, input int k,
                            output bit aborted);
      exp_t a;
      aborted = 0;
      for (int i = 0; i < k && i < T; i++) step(stall, 0, 0, rb(), r6(), r6());
      if (k > T) begin
         a = stall;
         a.pc_wr = 0; a.ir_wr = 0; a.mem_wr = 0; a.reg_wr = 0; a.mem_err = 1;
         step(a, 0, 0, rb(), r6(), r6());
         aborted = 1;
      end else begin
         step(done, 0, 1, rb(), r6(), r6());
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int kf, input int km);
      exp_t e;
      bit   ab;
      int   k;
      mem_phase(e_fetch(0), e_fetch(1), kf, ab);
      if (ab) return;
      k = kind_of(op, fn);
      step(e_decode(k == 0), 0, rb(), rb(), op, fn);
      case (k)
         1: begin
            step(e_memadr(), 0, rb(), rb(), r6(), r6());
            mem_phase(e_memrd(), e_memrd(), km, ab);
            if (!ab) begin
               e = '0; e.st = 4'd4; e.reg_wr = 1; e.mem2reg = 1;
               step(e, 0, rb(), rb(), r6(), r6());
            end
         end
         2: begin
            step(e_memadr(), 0, rb(), rb(), r6(), r6());
            mem_phase(e_memwr(), e_memwr(), km, ab);
         end
         3: begin
            e = '0; e.st = 4'd6; e.alu_srca = 1; e.aluop = alu_of(fn);
            step(e, 0, rb(), rb(), r6(), r6());
            e = '0; e.st = 4'd7; e.reg_wr = 1; e.reg_dst = 1;
            step(e, 0, rb(), rb(), r6(), r6());
         end
         4: begin
            e = '0; e.st = 4'd8; e.alu_srca = 1; e.aluop = 3'b110; e.pcs = 1;
            e.pc_wr = z;
            step(e, 0, rb(), z, r6(), r6());
         end
         default: ;
      endcase
   endtask

   function automatic int rand_wait();
      int r = $urandom_range(0, 19);
      if (r < 12) return 0;
      if (r < 18) return $urandom_range(1, 3);
      return $urandom_range(T - 1, T + 2);
   endfunction

   initial begin
      logic [5:0] op, fn;
      reset = 1; mem_ready = 0; zero = 0; opcode = '0; func = '0;
      @(posedge clk); #1;

      // Reset state
      step('0, 1, 1, 1, 6'b100011, 6'b0);
      step('0, 1, 0, 0, 6'b0, 6'b0);

      // Directed: add, lw, sw, beq taken / not taken, illegal op and func
      run_instr(6'b000000, 6'b100000, 0, 0, 0);
      run_instr(6'b100011, 6'b000000, 0, 0, 0);
      run_instr(6'b101011, 6'b000000, 0, 0, 0);
      run_instr(6'b000100, 6'b000000, 1, 0, 0);
      run_instr(6'b000100, 6'b000000, 0, 0, 0);
      run_instr(6'b000010, 6'b000000, 0, 0, 0);
      run_instr(6'b000000, 6'b101010, 0, 0, 0);

      // Store timeout, then store completing on the last allowed cycle
      run_instr(6'b101011, 6'b0, 0, 0, T + 1);
      run_instr(6'b101011, 6'b0, 0, 0, T);
      // Load timeout and fetch timeout
      run_instr(6'b100011, 6'b0, 0, 1, T + 3);
      run_instr(6'b000000, 6'b100001, 0, T + 1, 0);

      // Reset asserted mid-MEMRD, then a clean fetch
      step(e_fetch(1), 0, 1, 0, r6(), r6());
      step(e_decode(0), 0, 0, 0, 6'b100011, 6'b0);
      step(e_memadr(), 0, 1, 0, r6(), r6());
      step(e_memrd(), 0, 0, 0, r6(), r6());
      step('0, 1, 1, 0, r6(), r6());
      step('0, 1, 1, 0, r6(), r6());
      run_instr(6'b000000, 6'b100100, 0, 0, 0);

      // Randomized instruction mix
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 7))
            0: begin op = 6'b100011; fn = r6(); end
            1: begin op = 6'b101011; fn = r6(); end
            2: begin op = 6'b000100; fn = r6(); end
            3, 4: begin op = 6'b000000; fn = 6'(6'b100000 + $urandom_range(0, 4)); end
            5: begin op = 6'b000000; fn = r6(); end
            default: begin
               op = r6(); fn = r6();
               while (kind_of(op, fn) != 0) op = r6();
            end
         endcase
         run_instr(op, fn, rb(), rand_wait(), rand_wait());
      end

      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
